// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop input synchroniser, mid-bit sampling,
// configurable data width, optional odd/even parity, one or two stop bits,
// per-frame parity/framing flags and a busy indication.
module uart_rx_cfg #(
    parameter int HALF_BIT_PERIOD = 100,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int              CW      = $clog2(2 * HALF_BIT_PERIOD);
    localparam logic [CW-1:0]   HALF_M1 = CW'(HALF_BIT_PERIOD - 1);
    localparam logic [CW-1:0]   FULL_M1 = CW'(2 * HALF_BIT_PERIOD - 1);
    localparam logic [3:0]      DB_M1   = 4'(DATA_BITS - 1);
    localparam logic [3:0]      SB_M1   = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (HALF_BIT_PERIOD < 2) begin : g_bad_period
        $error("uart_rx_cfg: HALF_BIT_PERIOD must be >= 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 pbit_q, pbit_d;
    logic                 ferr_q, ferr_d;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 perr_q, perr_d;
    logic                 fout_q, fout_d;
    logic                 valid_q, valid_d;
    logic                 s_in, tick, stop_low, par_bad;

    assign s_in = sync_q[1];
    assign tick = (cnt_q == '0);

    // Parity check on the assembled word; mismatch sense depends on odd/even.
    always_comb begin
        par_bad = 1'b0;
        case (PARITY)
            1:       par_bad = ~(^shreg_q ^ pbit_q);
            2:       par_bad = ^shreg_q ^ pbit_q;
            default: par_bad = 1'b0;
        endcase
    end

    // Next-state logic: counter paces mid-bit samples, FSM walks the frame.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        pbit_d   = pbit_q;
        ferr_d   = ferr_q;
        armed_d  = armed_q;
        dout_d   = dout_q;
        perr_d   = perr_q;
        fout_d   = fout_q;
        valid_d  = 1'b0;
        stop_low = ferr_q | ~s_in;
        if (state_q != S_IDLE) cnt_d = tick ? FULL_M1 : cnt_q - 1'b1;
        case (state_q)
            S_IDLE: begin
                // Arming on a high line keeps a stuck-low line from retriggering.
                if (s_in) armed_d = 1'b1;
                if (armed_q && !s_in) begin
                    state_d = S_START;
                    cnt_d   = HALF_M1;
                end
            end
            S_START: if (tick) begin
                if (s_in) state_d = S_IDLE;
                else begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    ferr_d  = 1'b0;
                end
            end
            S_DATA: if (tick) begin
                shreg_d = {s_in, shreg_q[DATA_BITS-1:1]};
                bit_d   = bit_q + 4'd1;
                if (bit_q == DB_M1) begin
                    bit_d   = '0;
                    state_d = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: if (tick) begin
                pbit_d  = s_in;
                state_d = S_STOP;
            end
            S_STOP: if (tick) begin
                if (bit_q == SB_M1) begin
                    // Leave mid stop bit so a following start edge is caught.
                    dout_d  = shreg_q;
                    perr_d  = par_bad;
                    fout_d  = stop_low;
                    valid_d = 1'b1;
                    armed_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    ferr_d = stop_low;
                    bit_d  = bit_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            pbit_q  <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b0;
            dout_q  <= '0;
            perr_q  <= 1'b0;
            fout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], data_in};
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            pbit_q  <= pbit_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
            dout_q  <= dout_d;
            perr_q  <= perr_d;
            fout_q  <= fout_d;
            valid_q <= valid_d;
        end
    end

    assign data_out   = dout_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = fout_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three receivers (8N1, 8E1, 7N2) on one clock,
// serial frames built bit by bit, results checked against a frame-level model.
module tb_uart_rx_cfg;
    localparam int HBP = 100;
    localparam int BIT = 2 * HBP;
    localparam int CLK = 20;

    typedef struct {
        time        t;
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din0 = 1'b1, din1 = 1'b1, din2 = 1'b1;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, b0, b1, b2;
    int n_cmp = 0;
    int n_bad = 0;
    ev_t q0[$], q1[$], q2[$];

    always #(CLK / 2) clk = ~clk;

    uart_rx_cfg #(.HALF_BIT_PERIOD(HBP), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .data_in(din0), .data_out(d0), .valid(v0),
        .parity_err(pe0), .frame_err(fe0), .busy(b0));
    uart_rx_cfg #(.HALF_BIT_PERIOD(HBP), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .data_in(din1), .data_out(d1), .valid(v1),
        .parity_err(pe1), .frame_err(fe1), .busy(b1));
    uart_rx_cfg #(.HALF_BIT_PERIOD(HBP), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .data_in(din2), .data_out(d2), .valid(v2),
        .parity_err(pe2), .frame_err(fe2), .busy(b2));

    // Record every valid pulse with its time and the word/flags it presents.
    always @(negedge clk) begin
        ev_t e;
        if (v0) begin e.t = $time; e.d = {1'b0, d0}; e.pe = pe0; e.fe = fe0; q0.push_back(e); end
        if (v1) begin e.t = $time; e.d = {1'b0, d1}; e.pe = pe1; e.fe = fe1; q1.push_back(e); end
        if (v2) begin e.t = $time; e.d = {2'b0, d2}; e.pe = pe2; e.fe = fe2; q2.push_back(e); end
    end

    task automatic bitwait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic v);
        case (k)
            0:       din0 = v;
            1:       din1 = v;
            default: din2 = v;
        endcase
    endtask

    // Serialise one frame: start, data LSB first, optional parity, stop bits.
    task automatic send(input int k, input logic [8:0] d, input int nb, input int pm,
                        input logic pb, input logic [1:0] st, input int ns, output time tf);
        drive(k, 1'b0);
        tf = $time - 1;
        bitwait(BIT);
        for (int i = 0; i < nb; i++) begin drive(k, d[i]); bitwait(BIT); end
        if (pm != 0) begin drive(k, pb); bitwait(BIT); end
        for (int i = 0; i < ns; i++) begin drive(k, st[i]); bitwait(BIT); end
    endtask

    // Frame-level reference: word, parity verdict, stop verdict and the
    // negedge time at which the valid pulse is expected.
    function automatic ev_t model(input logic [8:0] d, input int nb, input int pm,
                                  input logic pb, input logic [1:0] st, input int ns,
                                  input time tf);
        ev_t x;
        int ones;
        logic [8:0] mask;
        mask = 9'((1 << nb) - 1);
        x.d  = d & mask;
        ones = $countones(x.d) + int'(pb);
        x.pe = (pm == 1) ? (ones % 2 == 0) : (pm == 2) ? (ones % 2 == 1) : 1'b0;
        x.fe = (st[0] == 1'b0) || (ns == 2 && st[1] == 1'b0);
        x.t  = tf + time'((HBP + (nb + ((pm != 0) ? 1 : 0) + ns) * BIT + 3) * CLK + CLK / 2);
        return x;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bitwait(3);
        n_cmp++; if ({d0, v0, pe0, fe0, b0} !== 12'h0) begin n_bad++;
            $display("FAIL reset_u0 got %h want 0", {d0, v0, pe0, fe0, b0}); end
        n_cmp++; if ({d1, v1, pe1, fe1, b1} !== 12'h0) begin n_bad++;
            $display("FAIL reset_u1 got %h want 0", {d1, v1, pe1, fe1, b1}); end
        n_cmp++; if ({d2, v2, pe2, fe2, b2} !== 11'h0) begin n_bad++;
            $display("FAIL reset_u2 got %h want 0", {d2, v2, pe2, fe2, b2}); end
        rst_n = 1'b1;
        bitwait(10);
        n_cmp++; if ({b0, b1, b2, v0, v1, v2} !== 6'h0) begin n_bad++;
            $display("FAIL idle_after_reset got %b want 0", {b0, b1, b2, v0, v1, v2}); end
    endtask

    task automatic test_8n1();
        time tf; ev_t e, x;
        q0.delete();
        send(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1, tf);
        x = model(9'h0A5, 8, 0, 1'b0, 2'b11, 1, tf);
        n_cmp++; if (q0.size() != 1) begin n_bad++;
            $display("FAIL a5_count got %0d want 1", q0.size()); end
        else begin
            e = q0.pop_front();
            n_cmp++; if (e.d !== x.d || e.pe !== 1'b0 || e.fe !== 1'b0) begin n_bad++;
                $display("FAIL a5_word got %h/%b/%b want %h/0/0", e.d, e.pe, e.fe, x.d); end
            n_cmp++; if (e.t > x.t + CLK || e.t + CLK < x.t) begin n_bad++;
                $display("FAIL a5_latency got t=%0t want t=%0t", e.t, x.t); end
        end
        bitwait(BIT);
    endtask

    task automatic test_random_8n1();
        time tf; ev_t e, x; logic [8:0] d; logic [1:0] st;
        for (int n = 0; n < 5; n++) begin
            d  = 9'($urandom_range(0, 255));
            st = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11;
            q0.delete();
            send(0, d, 8, 0, 1'b0, st, 1, tf);
            x = model(d, 8, 0, 1'b0, st, 1, tf);
            n_cmp++; if (q0.size() != 1) begin n_bad++;
                $display("FAIL rnd8n1_count got %0d want 1", q0.size()); end
            else begin
                e = q0.pop_front();
                n_cmp++; if (e.d !== x.d || e.pe !== x.pe || e.fe !== x.fe) begin n_bad++;
                    $display("FAIL rnd8n1_word got %h/%b/%b want %h/%b/%b",
                             e.d, e.pe, e.fe, x.d, x.pe, x.fe); end
                n_cmp++; if (e.t > x.t + CLK || e.t + CLK < x.t) begin n_bad++;
                    $display("FAIL rnd8n1_latency got t=%0t want t=%0t", e.t, x.t); end
            end
            drive(0, 1'b1);
            bitwait(BIT);
        end
    endtask

    task automatic test_glitch();
        int i;
        q0.delete();
        drive(0, 1'b0);
        bitwait(5);
        n_cmp++; if (b0 !== 1'b1) begin n_bad++;
            $display("FAIL glitch_busy_rise got %b want 1", b0); end
        bitwait(45);
        drive(0, 1'b1);
        i = 0;
        while (b0 !== 1'b0 && i < 80) begin bitwait(1); i++; end
        n_cmp++; if (50 + i > HBP + 4) begin n_bad++;
            $display("FAIL glitch_busy_fall got %0d clk want <= %0d", 50 + i, HBP + 4); end
        bitwait(BIT);
        n_cmp++; if (q0.size() != 0) begin n_bad++;
            $display("FAIL glitch_valid got %0d pulses want 0", q0.size()); end
    endtask

    task automatic test_frame_err();
        time tf; ev_t e;
        q0.delete();
        send(0, 9'h055, 8, 0, 1'b0, 2'b00, 1, tf);
        bitwait(1000);
        n_cmp++; if (q0.size() != 1) begin n_bad++;
            $display("FAIL ferr_count got %0d want 1", q0.size()); end
        else begin
            e = q0.pop_front();
            n_cmp++; if (e.d !== 9'h055 || e.fe !== 1'b1) begin n_bad++;
                $display("FAIL ferr_word got %h/%b want 055/1", e.d, e.fe); end
        end
        n_cmp++; if (b0 !== 1'b0) begin n_bad++;
            $display("FAIL ferr_retrigger busy got %b want 0", b0); end
        drive(0, 1'b1);
        bitwait(BIT);
        send(0, 9'h03C, 8, 0, 1'b0, 2'b11, 1, tf);
        n_cmp++; if (q0.size() != 1) begin n_bad++;
            $display("FAIL ferr_next_count got %0d want 1", q0.size()); end
        else begin
            e = q0.pop_front();
            n_cmp++; if (e.d !== 9'h03C || e.fe !== 1'b0) begin n_bad++;
                $display("FAIL ferr_next_word got %h/%b want 03c/0", e.d, e.fe); end
        end
        bitwait(BIT);
    endtask

    task automatic test_reset_mid_frame();
        time tf; ev_t e;
        logic [7:0] d;
        d = 8'hF3;
        q0.delete();
        drive(0, 1'b0);
        bitwait(BIT);
        for (int i = 0; i < 4; i++) begin drive(0, d[i]); bitwait(BIT); end
        drive(0, d[4]);
        bitwait(BIT / 2);
        rst_n = 1'b0;
        bitwait(3);
        n_cmp++; if ({d0, v0, pe0, fe0, b0} !== 12'h0) begin n_bad++;
            $display("FAIL midrst_outputs got %h want 0", {d0, v0, pe0, fe0, b0}); end
        rst_n = 1'b1;
        bitwait(BIT / 2 - 3);
        for (int i = 5; i < 8; i++) begin drive(0, d[i]); bitwait(BIT); end
        drive(0, 1'b1);
        bitwait(2 * BIT);
        n_cmp++; if (q0.size() != 0) begin n_bad++;
            $display("FAIL midrst_valid got %0d pulses want 0", q0.size()); end
        send(0, 9'h0FF, 8, 0, 1'b0, 2'b11, 1, tf);
        n_cmp++; if (q0.size() != 1) begin n_bad++;
            $display("FAIL midrst_ff_count got %0d want 1", q0.size()); end
        else begin
            e = q0.pop_front();
            n_cmp++; if (e.d !== 9'h0FF || e.fe !== 1'b0) begin n_bad++;
                $display("FAIL midrst_ff_word got %h/%b want 0ff/0", e.d, e.fe); end
        end
        bitwait(BIT);
    endtask

    task automatic test_parity();
        time tf; ev_t e, x; logic [8:0] d; logic pb;
        for (int n = 0; n < 6; n++) begin
            if (n < 2) begin d = 9'h003; pb = (n == 0); end
            else begin d = 9'($urandom_range(0, 255)); pb = 1'($urandom_range(0, 1)); end
            q1.delete();
            send(1, d, 8, 2, pb, 2'b11, 1, tf);
            x = model(d, 8, 2, pb, 2'b11, 1, tf);
            n_cmp++; if (q1.size() != 1) begin n_bad++;
                $display("FAIL par_count got %0d want 1", q1.size()); end
            else begin
                e = q1.pop_front();
                n_cmp++; if (e.d !== x.d || e.pe !== x.pe || e.fe !== 1'b0) begin n_bad++;
                    $display("FAIL par_word got %h/%b/%b want %h/%b/0", e.d, e.pe, e.fe, x.d, x.pe); end
                n_cmp++; if (e.t > x.t + CLK || e.t + CLK < x.t) begin n_bad++;
                    $display("FAIL par_latency got t=%0t want t=%0t", e.t, x.t); end
            end
            bitwait(BIT);
        end
    endtask

    task automatic test_back_to_back();
        time tf, tf2; ev_t e, e2, x; logic [8:0] d; logic [1:0] st;
        q2.delete();
        send(2, 9'h012, 7, 0, 1'b0, 2'b11, 2, tf);
        send(2, 9'h06B, 7, 0, 1'b0, 2'b11, 2, tf2);
        n_cmp++; if (q2.size() != 2) begin n_bad++;
            $display("FAIL b2b_count got %0d want 2", q2.size()); end
        else begin
            e  = q2.pop_front();
            e2 = q2.pop_front();
            n_cmp++; if (e.d !== 9'h012 || e2.d !== 9'h06B) begin n_bad++;
                $display("FAIL b2b_words got %h,%h want 012,06b", e.d, e2.d); end
            n_cmp++; if (e2.t - e.t != time'(2000 * CLK)) begin n_bad++;
                $display("FAIL b2b_spacing got %0t want %0t", e2.t - e.t, time'(2000 * CLK)); end
        end
        bitwait(BIT);
        for (int n = 0; n < 4; n++) begin
            d  = 9'($urandom_range(0, 127));
            st = 2'($urandom_range(0, 3));
            q2.delete();
            send(2, d, 7, 0, 1'b0, st, 2, tf);
            x = model(d, 7, 0, 1'b0, st, 2, tf);
            n_cmp++; if (q2.size() != 1) begin n_bad++;
                $display("FAIL rnd7n2_count got %0d want 1", q2.size()); end
            else begin
                e = q2.pop_front();
                n_cmp++; if (e.d !== x.d || e.fe !== x.fe || e.pe !== 1'b0) begin n_bad++;
                    $display("FAIL rnd7n2_word got %h/%b/%b want %h/%b/0", e.d, e.fe, e.pe, x.d, x.fe); end
                n_cmp++; if (e.t > x.t + CLK || e.t + CLK < x.t) begin n_bad++;
                    $display("FAIL rnd7n2_latency got t=%0t want t=%0t", e.t, x.t); end
            end
            drive(2, 1'b1);
            bitwait(BIT);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_random_8n1();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_parity();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
